// File: rtl/dec_ctr_seq.sv
// rtl/dec_ctr_seq.sv - run-control sequencer for a cascaded BCD decade counter
// Optional lap capture register: DEC_CTR_LAP_EN
module dec_ctr_seq #(
    parameter int DIGITS = 2,
    parameter int DIV    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   limit,
`ifdef DEC_CTR_LAP_EN
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   lap_q,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic [1:0]            state,
    output logic                  running,
    output logic                  done
);

    localparam int          W        = 4 * DIGITS;
    localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [15:0]    pre_q, pre_d;
    logic [W-1:0]   lim_q, lim_d;
    logic           done_q, done_d;
    logic           running_q, running_d;
`ifdef DEC_CTR_LAP_EN
    logic [W-1:0]   lapv_q, lapv_d;
`endif

    logic           tick;
    logic           go;
    logic [W-1:0]   cnt_inc;

    // Ripple-carry BCD increment: each digit wraps 9->0 and carries upward.
    // Digits at or above 9 are treated as 9 so the result stays BCD.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        logic [3:0]   d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick    = (pre_q == PRE_LAST);
    assign go      = start && !stop;
    assign cnt_inc = bcd_inc(cnt_q);

    // Next-state logic: clear overrides everything, stop overrides start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        lim_d   = lim_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (go) begin
                        state_d = ST_RUN;
                        lim_d   = limit;
                        pre_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // A tick that coincides with stop is dropped; the
                        // prescaler keeps its phase for the resume.
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        cnt_d = cnt_inc;
                        // An out-of-range limit digit can never equal a
                        // BCD count, so such a limit never terminates.
                        if (cnt_inc == lim_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                end
                ST_PAUSE: begin
                    if (go) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (go) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        pre_d   = '0;
                        lim_d   = limit;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

`ifdef DEC_CTR_LAP_EN
    // Lap capture takes the count as it stands before any same-cycle tick.
    always_comb begin
        lapv_d = lapv_q;
        if (clear) begin
            lapv_d = '0;
        end else if (lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
            lapv_d = cnt_q;
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            lim_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
`ifdef DEC_CTR_LAP_EN
            lapv_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            lim_q     <= lim_d;
            done_q    <= done_d;
            running_q <= running_d;
`ifdef DEC_CTR_LAP_EN
            lapv_q    <= lapv_d;
`endif
        end
    end

    assign q       = cnt_q;
    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;
`ifdef DEC_CTR_LAP_EN
    assign lap_q   = lapv_q;
`endif

endmodule

// File: tb/tb_dec_ctr_seq.sv
// tb/tb_dec_ctr_seq.sv - self-checking bench for dec_ctr_seq (DIV=4 and DIV=1 instances)
module tb_dec_ctr_seq;

    logic       clk = 1'b0;
    logic       rst, start, stop, clear, lap;
    logic [7:0] limit;

    logic [7:0] u0_q, u1_q;
    logic [1:0] u0_state, u1_state;
    logic       u0_running, u1_running, u0_done, u1_done;
`ifdef DEC_CTR_LAP_EN
    logic [7:0] u0_lap_q, u1_lap_q;
`endif

    int tests = 0;
    int fails = 0;

    int m_st[2], m_cnt[2], m_pre[2], m_lim[2], m_done[2], m_lap[2];

    always #5 clk = ~clk;

    dec_ctr_seq #(.DIGITS(2), .DIV(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .limit(limit),
`ifdef DEC_CTR_LAP_EN
        .lap(lap), .lap_q(u0_lap_q),
`endif
        .q(u0_q), .state(u0_state), .running(u0_running), .done(u0_done)
    );

    dec_ctr_seq #(.DIGITS(2), .DIV(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .limit(limit),
`ifdef DEC_CTR_LAP_EN
        .lap(lap), .lap_q(u1_lap_q),
`endif
        .q(u1_q), .state(u1_state), .running(u1_running), .done(u1_done)
    );

    function automatic int bcd2int(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count held as a decimal integer, limit as an
    // integer (-1 when unmatchable), prescaler as a plain cycle counter.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int dv;
            dv = (k == 0) ? 4 : 1;
            if (rst) begin
                m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0;
                m_lim[k] = 0; m_done[k] = 0; m_lap[k] = 0;
            end else begin
                m_done[k] = 0;
                if (clear) m_lap[k] = 0;
                else if (lap && (m_st[k] == 1 || m_st[k] == 2)) m_lap[k] = m_cnt[k];
                if (clear) begin
                    m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0;
                end else begin
                    case (m_st[k])
                        0: if (start && !stop) begin
                            m_st[k] = 1; m_lim[k] = bcd2int(limit); m_pre[k] = 0;
                        end
                        1: if (stop) begin
                            m_st[k] = 2;
                        end else if (m_pre[k] == dv - 1) begin
                            m_pre[k] = 0;
                            m_cnt[k] = (m_cnt[k] + 1) % 100;
                            if (m_cnt[k] == m_lim[k]) begin
                                m_done[k] = 1; m_st[k] = 3;
                            end
                        end else begin
                            m_pre[k] = m_pre[k] + 1;
                        end
                        2: if (start && !stop) m_st[k] = 1;
                        default: if (start && !stop) begin
                            m_st[k] = 1; m_cnt[k] = 0; m_pre[k] = 0;
                            m_lim[k] = bcd2int(limit);
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("u0_q",       32'(u0_q),       32'(int2bcd(m_cnt[0])));
        chk("u0_state",   32'(u0_state),   32'(m_st[0]));
        chk("u0_running", 32'(u0_running), 32'(m_st[0] == 1));
        chk("u0_done",    32'(u0_done),    32'(m_done[0]));
        chk("u1_q",       32'(u1_q),       32'(int2bcd(m_cnt[1])));
        chk("u1_state",   32'(u1_state),   32'(m_st[1]));
        chk("u1_running", 32'(u1_running), 32'(m_st[1] == 1));
        chk("u1_done",    32'(u1_done),    32'(m_done[1]));
`ifdef DEC_CTR_LAP_EN
        chk("u0_lap_q",   32'(u0_lap_q),   32'(int2bcd(m_lap[0])));
        chk("u1_lap_q",   32'(u1_lap_q),   32'(int2bcd(m_lap[1])));
`endif
    endtask

    // One clock: model follows the edge, outputs are compared at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_u0_q(input logic [7:0] target, input int budget);
        int n;
        n = 0;
        while (u0_q !== target && n < budget) begin
            step();
            n++;
        end
        chk("wait_u0_q_timeout", 32'(u0_q), 32'(target));
    endtask

    initial begin
        lap   = 1'b0;
        // Reset with random control inputs
        rst   = 1'b1;
        start = 1'(($urandom)); stop = 1'(($urandom)); clear = 1'(($urandom));
        limit = 8'($urandom);
        step();
        start = 1'(($urandom)); stop = 1'(($urandom)); clear = 1'(($urandom));
        limit = 8'($urandom);
        step();
        chk("rst_q", 32'(u0_q), 32'h00);
        chk("rst_state", 32'(u0_state), 32'd0);
        chk("rst_running", 32'(u0_running), 32'd0);
        chk("rst_done", 32'(u0_done), 32'd0);
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        step();

        // Carry and terminal at 12
        limit = 8'h12; start = 1'b1; step(); start = 1'b0;
        chk("ct_state_run", 32'(u0_state), 32'd1);
        chk("ct_running", 32'(u0_running), 32'd1);
        steps(3);
        chk("ct_q_before_first", 32'(u0_q), 32'h00);
        step();
        chk("ct_q_first", 32'(u0_q), 32'h01);
        steps(32);
        chk("ct_q_09", 32'(u0_q), 32'h09);
        steps(4);
        chk("ct_q_carry_10", 32'(u0_q), 32'h10);
        steps(8);
        chk("ct_q_12", 32'(u0_q), 32'h12);
        chk("ct_done", 32'(u0_done), 32'd1);
        chk("ct_state_done", 32'(u0_state), 32'd3);
        step();
        chk("ct_done_pulse", 32'(u0_done), 32'd0);
        steps(20);
        chk("ct_q_held", 32'(u0_q), 32'h12);
        chk("ct_state_held", 32'(u0_state), 32'd3);

        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_state", 32'(u0_state), 32'd0);
        chk("clr_q", 32'(u0_q), 32'h00);

        // Pause with prescaler mid-count, then resume
        limit = 8'h99; start = 1'b1; step(); start = 1'b0;
        steps(20);
        chk("pr_q_05", 32'(u0_q), 32'h05);
        steps(2);
        stop = 1'b1; steps(30);
        chk("pr_q_hold", 32'(u0_q), 32'h05);
        chk("pr_state_pause", 32'(u0_state), 32'd2);
        start = 1'b1; step();
        chk("pr_start_stop_pause", 32'(u0_state), 32'd2);
        stop = 1'b0; step(); start = 1'b0;
        chk("pr_resume_state", 32'(u0_state), 32'd1);
        chk("pr_resume_q", 32'(u0_q), 32'h05);
        step();
        chk("pr_resume_q1", 32'(u0_q), 32'h05);
        step();
        chk("pr_resume_q2", 32'(u0_q), 32'h06);

        // start+stop+clear together in RUN
        start = 1'b1; stop = 1'b1; clear = 1'b1; step();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        chk("pri_state", 32'(u0_state), 32'd0);
        chk("pri_q", 32'(u0_q), 32'h00);
        chk("pri_done", 32'(u0_done), 32'd0);

        // Reset during RUN at 33
        limit = 8'h99; start = 1'b1; step(); start = 1'b0;
        wait_u0_q(8'h33, 200);
        rst = 1'b1; start = 1'b1; clear = 1'b0; stop = 1'b0; step();
        rst = 1'b0; start = 1'b0;
        chk("mrst_q", 32'(u0_q), 32'h00);
        chk("mrst_state", 32'(u0_state), 32'd0);
        chk("mrst_running", 32'(u0_running), 32'd0);
        chk("mrst_done", 32'(u0_done), 32'd0);

        // DIV=1 full wrap with limit 00
        limit = 8'h00; start = 1'b1; step(); start = 1'b0;
        steps(50);
        chk("wr_q_50", 32'(u1_q), 32'h50);
        steps(49);
        chk("wr_q_99", 32'(u1_q), 32'h99);
        chk("wr_done_early", 32'(u1_done), 32'd0);
        step();
        chk("wr_q_00", 32'(u1_q), 32'h00);
        chk("wr_done", 32'(u1_done), 32'd1);
        chk("wr_state", 32'(u1_state), 32'd3);

        // Unmatchable limit digit: counter wraps forever
        clear = 1'b1; step(); clear = 1'b0;
        limit = 8'h1A; start = 1'b1; step(); start = 1'b0;
        steps(105);
        chk("inv_q", 32'(u1_q), 32'h05);
        chk("inv_state", 32'(u1_state), 32'd1);

`ifdef DEC_CTR_LAP_EN
        clear = 1'b1; step(); clear = 1'b0;
        limit = 8'h99; start = 1'b1; step(); start = 1'b0;
        wait_u0_q(8'h07, 100);
        lap = 1'b1; step(); lap = 1'b0;
        chk("lap_cap", 32'(u0_lap_q), 32'h07);
        wait_u0_q(8'h08, 10);
        chk("lap_keep", 32'(u0_lap_q), 32'h07);
        clear = 1'b1; step(); clear = 1'b0;
        chk("lap_clr", 32'(u0_lap_q), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
